// File: rtl/csi2tx_rawn_p2b_if.sv
// csi2tx_rawn_p2b_if: pixel-in / packed-word-out stream bundle for the RAWn packer
//   pixel_data/pixel_vld/pixel_last/pixel_rdy : sensor-side pixel stream
//   dw/dw_vld/dw_rdy/dw_last/dw_byte_cnt      : packet-builder-side word stream
//   master modport : the packer itself
//   slave modport  : the surrounding pixel source and word sink
interface csi2tx_rawn_p2b_if #(
    parameter int PIX_W_MAX = 8,
    parameter int DW_W      = 32,
    parameter int BC_W      = 3
);
    logic [PIX_W_MAX-1:0] pixel_data;
    logic                 pixel_vld;
    logic                 pixel_last;
    logic                 pixel_rdy;
    logic [DW_W-1:0]      dw;
    logic                 dw_vld;
    logic                 dw_rdy;
    logic                 dw_last;
    logic [BC_W-1:0]      dw_byte_cnt;
    modport master (
        input  pixel_data, pixel_vld, pixel_last, dw_rdy,
        output pixel_rdy, dw, dw_vld, dw_last, dw_byte_cnt
    );
    modport slave (
        output pixel_data, pixel_vld, pixel_last, dw_rdy,
        input  pixel_rdy, dw, dw_vld, dw_last, dw_byte_cnt
    );
endinterface

// File: rtl/csi2tx_rawn_p2b.sv
// csi2tx_rawn_p2b: packs RAW6/7/8-style pixels LSB-first into DW_W-bit words
//   clk       : block clock
//   rst_n     : synchronous active-low reset
//   conv_en   : low clears the packer exactly like reset
//   pix_width : pixel width 1..PIX_W_MAX, latched on the first pixel of each line
//   bus       : pixel input and packed-word output streams (master side)
module csi2tx_rawn_p2b #(
    parameter int PIX_W_MAX = 8,
    parameter int DW_W      = 32,
    parameter int BC_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  conv_en,
    input  logic [3:0]            pix_width,
    csi2tx_rawn_p2b_if.master     bus
);
    localparam int AW = DW_W + PIX_W_MAX;
    localparam int FW = $clog2(AW + 1);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]           state;
    logic [AW-1:0]        acc, acc_m;
    logic [FW-1:0]        fill, fill_m;
    logic [3:0]           wreg, w_eff;
    logic                 line_open, run;
    logic                 slot_free, full, move, take;
    logic [PIX_W_MAX-1:0] pix_m;

    // run keeps pixel_rdy low for the cycle right after a clear
    always_comb begin
        slot_free     = !bus.dw_vld || bus.dw_rdy;
        full          = fill >= FW'(DW_W);
        move          = state == ACCUM && full && slot_free;
        bus.pixel_rdy = run && state == ACCUM && (!full || slot_free);
        take          = bus.pixel_vld && bus.pixel_rdy;
        w_eff         = line_open ? wreg : pix_width;
        for (int i = 0; i < PIX_W_MAX; i++)
            pix_m[i] = bus.pixel_data[i] & (i < int'(w_eff));
        acc_m         = move ? acc >> DW_W : acc;
        fill_m        = move ? fill - FW'(DW_W) : fill;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !conv_en) begin
            state           <= ACCUM;
            acc             <= '0;
            fill            <= '0;
            wreg            <= '0;
            line_open       <= 1'b0;
            run             <= 1'b0;
            bus.dw          <= '0;
            bus.dw_vld      <= 1'b0;
            bus.dw_last     <= 1'b0;
            bus.dw_byte_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (bus.dw_rdy)
                bus.dw_vld <= 1'b0;
            if (state == ACCUM) begin
                // new pixel lands above whatever remains after this cycle's word move
                acc  <= take ? acc_m | (AW'(pix_m) << fill_m) : acc_m;
                fill <= take ? fill_m + FW'(w_eff) : fill_m;
                if (take) begin
                    line_open <= 1'b1;
                    if (!line_open)
                        wreg <= pix_width;
                    if (bus.pixel_last)
                        state <= FLUSH;
                end
                if (move) begin
                    bus.dw          <= acc[DW_W-1:0];
                    bus.dw_vld      <= 1'b1;
                    bus.dw_last     <= 1'b0;
                    bus.dw_byte_cnt <= BC_W'(DW_W / 8);
                end
            end else if (slot_free) begin
                // bits above fill are always zero, so the tail word is already padded
                bus.dw     <= acc[DW_W-1:0];
                bus.dw_vld <= 1'b1;
                if (fill > FW'(DW_W)) begin
                    acc             <= acc >> DW_W;
                    fill            <= fill - FW'(DW_W);
                    bus.dw_last     <= 1'b0;
                    bus.dw_byte_cnt <= BC_W'(DW_W / 8);
                end else begin
                    acc             <= '0;
                    fill            <= '0;
                    line_open       <= 1'b0;
                    state           <= ACCUM;
                    bus.dw_last     <= 1'b1;
                    bus.dw_byte_cnt <= BC_W'((fill + FW'(7)) >> 3);
                end
            end
        end
    end
endmodule

// File: tb/tb_csi2tx_rawn_p2b.sv
// tb_csi2tx_rawn_p2b: randomized and directed checks of the RAWn packer against a bitstream model
module tb_csi2tx_rawn_p2b;
    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [2:0]  cnt;
    } wd_t;

    logic       clk, rst_n, conv_en;
    logic [3:0] pix_width;
    int         total = 0, bad = 0;
    int         rdy_mode = 0;
    logic [7:0] pix_buf [64];
    wd_t        exp_q[$], got_q[$], c1_q[$];
    wd_t        cur, prev;
    logic       prev_hold = 1'b0;

    csi2tx_rawn_p2b_if bus();

    csi2tx_rawn_p2b dut (
        .clk(clk),
        .rst_n(rst_n),
        .conv_en(conv_en),
        .pix_width(pix_width),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: concatenate pixel bits LSB-first, cut into 32-bit words, mark the tail
    task automatic model_line(input int w, input int n);
        logic [31:0] word = '0;
        int pos = 0;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < w; b++) begin
                word[pos] = pix_buf[i][b];
                pos++;
                if (pos == 32) begin
                    exp_q.push_back('{word, 1'b0, 3'd4});
                    word = '0;
                    pos = 0;
                end
            end
        if (pos > 0)
            exp_q.push_back('{word, 1'b1, 3'((pos + 7) / 8)});
        else
            exp_q[exp_q.size() - 1].last = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] p, input logic last, input bit gaps);
        bit ok = 0;
        if (gaps)
            repeat ($urandom_range(0, 2)) tick();
        bus.pixel_data = p;
        bus.pixel_last = last;
        bus.pixel_vld  = 1'b1;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = bus.pixel_rdy;
            tick();
        end
        if (!ok)
            check("pix_timeout", 0, 1);
        bus.pixel_vld  = 1'b0;
        bus.pixel_last = 1'b0;
    endtask

    task automatic send_line(input int w, input int n, input int w_mid, input int mid_at, input bit gaps);
        pix_width = 4'(w);
        model_line(w, n);
        for (int i = 0; i < n; i++) begin
            if (i == mid_at)
                pix_width = 4'(w_mid);
            send_pix(pix_buf[i], i == n - 1, gaps);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++)
            @(posedge clk);
        tick();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic case1();
        got_q.delete();
        for (int i = 0; i < 32; i++)
            pix_buf[i] = 8'(i + 1);
        send_line(7, 32, 7, -1, 0);
        drain();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.dw_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    always @(negedge clk) begin
        cur = '{bus.dw, bus.dw_last, bus.dw_byte_cnt};
        if (prev_hold)
            check("hold_stable", cur, prev);
        prev_hold = rst_n && conv_en && bus.dw_vld && !bus.dw_rdy;
        prev = cur;
        if (rst_n && conv_en && bus.dw_vld && bus.dw_rdy) begin
            got_q.push_back(cur);
            if (exp_q.size() == 0)
                check("extra_word", 1, 0);
            else
                check("word", cur, exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        conv_en = 1'b1;
        pix_width = 4'd7;
        bus.pixel_data = '0;
        bus.pixel_vld = 1'b0;
        bus.pixel_last = 1'b0;
        bus.dw_rdy = 1'b1;
        repeat (3) tick();
        check("reset_out", {bus.dw, bus.dw_vld, bus.dw_last, bus.dw_byte_cnt, bus.pixel_rdy}, 0);
        rst_n = 1'b1;
        tick();

        case1();
        c1_q = got_q;
        check("c1_count", got_q.size(), 7);
        check("c1_w0", got_q[0].d, 32'h5080_C101);
        check("c1_tail", {got_q[6].last, got_q[6].cnt}, {1'b1, 3'd4});

        got_q.delete();
        for (int i = 0; i < 4; i++)
            pix_buf[i] = 8'h3F;
        send_line(6, 4, 6, -1, 0);
        drain();
        check("raw6_count", got_q.size(), 1);
        check("raw6_w0", got_q[0], {32'h00FF_FFFF, 1'b1, 3'd3});

        got_q.delete();
        for (int i = 0; i < 5; i++)
            pix_buf[i] = 8'hAA + 8'(i * 17);
        send_line(8, 5, 8, -1, 0);
        drain();
        check("raw8_w0", got_q[0], {32'hDDCC_BBAA, 1'b0, 3'd4});
        check("raw8_w1", got_q[1], {32'h0000_00EE, 1'b1, 3'd1});

        for (int i = 0; i < 32; i++)
            pix_buf[i] = 8'($urandom);
        rdy_mode = 2;
        tick();
        fork
            send_line(7, 32, 7, -1, 0);
            begin
                for (int t = 0; t < 200 && !bus.dw_vld; t++)
                    @(negedge clk);
                repeat (10) @(negedge clk);
                check("bp_pixel_rdy", bus.pixel_rdy, 0);
                rdy_mode = 0;
            end
        join
        drain();

        pix_width = 4'd7;
        for (int i = 0; i < 3; i++)
            send_pix(8'($urandom), 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid", {bus.dw, bus.dw_vld, bus.dw_last, bus.dw_byte_cnt, bus.pixel_rdy}, 0);
        tick();
        case1();
        for (int i = 0; i < 7; i++)
            check("rst_repeat", got_q[i], c1_q[i]);

        for (int i = 0; i < 20; i++)
            pix_buf[i] = 8'($urandom);
        send_line(7, 20, 6, 4, 0);
        for (int i = 0; i < 20; i++)
            pix_buf[i] = 8'($urandom);
        send_line(6, 20, 6, -1, 0);
        drain();

        rdy_mode = 1;
        for (int l = 0; l < 12; l++) begin
            int w = $urandom_range(1, 8);
            int n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++)
                pix_buf[i] = 8'($urandom);
            send_line(w, n, $urandom_range(1, 8), $urandom_range(1, 39), 1);
        end
        drain();
        rdy_mode = 0;

        for (int i = 0; i < 2; i++)
            send_pix(8'($urandom), 1'b0, 0);
        conv_en = 1'b0;
        tick();
        conv_en = 1'b1;
        check("conv_clear", {bus.dw_vld, bus.pixel_rdy}, 0);
        tick();
        for (int i = 0; i < 9; i++)
            pix_buf[i] = 8'($urandom);
        send_line(5, 9, 5, -1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
